// File: rtl/mem_dump_reader_if.sv
// Memory read port and byte-stream port of the dump reader.
// master: the reader; slave: the memory plus transmitter side.
interface mem_dump_reader_if #(
    parameter int unsigned B = 16,
    parameter int unsigned W = 11
);
    logic         mem_rd_en;
    logic [W-1:0] mem_addr;
    logic [B-1:0] mem_r_data;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         tx_ready;

    modport master (
        output mem_rd_en,
        output mem_addr,
        input  mem_r_data,
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  mem_rd_en,
        input  mem_addr,
        output mem_r_data,
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/mem_dump_reader.sv
// Reads a block of consecutive memory words and streams them out MSB byte first
// on an 8-bit valid/ready port; used to dump memory over the debug UART.
module mem_dump_reader #(
    parameter int unsigned B = 16,
    parameter int unsigned W = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [W-1:0]     base_addr_i,
    input  logic [W:0]       count_i,
    output logic             busy_o,
    output logic             done_o,
    mem_dump_reader_if.master dump_io
);

    localparam int unsigned NB   = B / 8;
    localparam int unsigned IdxW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NB - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StSend,
        StFin
    } state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    addr_q, addr_d;
    logic [W:0]      words_left_q, words_left_d;
    logic [IdxW-1:0] byte_idx_q, byte_idx_d;
    logic [B-1:0]    shift_q, shift_d;

    logic            mem_rd_en;
    logic [W-1:0]    mem_addr;
    logic [7:0]      tx_data;
    logic            tx_valid;
    logic            done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            words_left_q <= '0;
            byte_idx_q   <= '0;
            shift_q      <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            words_left_q <= words_left_d;
            byte_idx_q   <= byte_idx_d;
            shift_q      <= shift_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        words_left_d = words_left_q;
        byte_idx_d   = byte_idx_q;
        shift_d      = shift_q;
        mem_rd_en    = 1'b0;
        mem_addr     = '0;
        tx_data      = '0;
        tx_valid     = 1'b0;
        done         = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    if (count_i != '0) begin
                        addr_d       = base_addr_i;
                        words_left_d = count_i;
                        state_d      = StRead;
                    end else begin
                        state_d = StFin;
                    end
                end
            end

            // Memory data is combinational, so it is only sampled while rd_en is high.
            StRead: begin
                mem_rd_en  = 1'b1;
                mem_addr   = addr_q;
                shift_d    = dump_io.mem_r_data;
                byte_idx_d = '0;
                state_d    = StSend;
            end

            StSend: begin
                tx_valid = 1'b1;
                tx_data  = shift_q[B-1 -: 8];
                if (dump_io.tx_ready) begin
                    shift_d    = shift_q << 8;
                    byte_idx_d = byte_idx_q + 1'b1;
                    if (byte_idx_q == LastIdx) begin
                        words_left_d = words_left_q - 1'b1;
                        addr_d       = addr_q + 1'b1;
                        state_d      = (words_left_q > (W + 1)'(1)) ? StRead : StFin;
                    end
                end
            end

            StFin: begin
                done    = 1'b1;
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign dump_io.mem_rd_en = mem_rd_en;
    assign dump_io.mem_addr  = mem_addr;
    assign dump_io.tx_data   = tx_data;
    assign dump_io.tx_valid  = tx_valid;
    assign done_o            = done;
    assign busy_o            = (state_q != StIdle);

endmodule

// File: tb/tb_mem_dump_reader.sv
// Self-checking bench for mem_dump_reader: table vectors, random transfers against a
// queue-based model of the expected byte/address stream, and reset/restart sequences.
module tb_mem_dump_reader;

    localparam int unsigned B     = 16;
    localparam int unsigned W     = 11;
    localparam int unsigned NB    = B / 8;
    localparam int unsigned Depth = 1 << W;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start_i;
    logic [W-1:0] base_addr_i;
    logic [W:0]   count_i;
    logic         busy_o;
    logic         done_o;

    mem_dump_reader_if #(.B(B), .W(W)) dif ();

    mem_dump_reader #(.B(B), .W(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .base_addr_i (base_addr_i),
        .count_i     (count_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .dump_io     (dif)
    );

    logic [B-1:0] mem [Depth];
    // Poison value when not enabled, so an illegal sample corrupts the stream.
    assign dif.mem_r_data = dif.mem_rd_en ? mem[dif.mem_addr] : B'(16'hDEAD);

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;

    logic [7:0]   obs_bytes [$];
    logic [W-1:0] obs_addrs [$];
    int rd_cnt, valid_cnt, busy_cnt, done_cnt, done_cyc, stall_viol;
    logic       prev_stall;
    logic [7:0] prev_data;
    int rmode = 0;
    int rphase = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clear_obs();
        obs_bytes.delete();
        obs_addrs.delete();
        rd_cnt = 0; valid_cnt = 0; busy_cnt = 0; done_cnt = 0; done_cyc = -1; stall_viol = 0;
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Ready driver: 0 = always ready, 1 = 1,0,0 repeating, 2 = random.
    initial begin
        dif.tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            rphase++;
            case (rmode)
                0:       dif.tx_ready = 1'b1;
                1:       dif.tx_ready = (rphase % 3 == 0);
                default: dif.tx_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor samples on the falling edge.
    initial begin
        prev_stall = 1'b0;
        prev_data  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (dif.mem_rd_en) begin
                    rd_cnt++;
                    obs_addrs.push_back(dif.mem_addr);
                end
                if (dif.tx_valid) valid_cnt++;
                if (dif.tx_valid && dif.tx_ready) obs_bytes.push_back(dif.tx_data);
                if (prev_stall && (!dif.tx_valid || dif.tx_data != prev_data)) stall_viol++;
                prev_stall = dif.tx_valid && !dif.tx_ready;
                prev_data  = dif.tx_data;
                if (busy_o) busy_cnt++;
                if (done_o) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
            end
        end
    end

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_tx_valid"}, longint'(dif.tx_valid), 0);
        chk({tag, "_tx_data"}, longint'(dif.tx_data), 0);
        chk({tag, "_rd_en"}, longint'(dif.mem_rd_en), 0);
        chk({tag, "_mem_addr"}, longint'(dif.mem_addr), 0);
        chk({tag, "_busy"}, longint'(busy_o), 0);
        chk({tag, "_done"}, longint'(done_o), 0);
    endtask

    task automatic run_xfer(input int base, input int cnt, input int mode, input int exp_lat,
                            input int restart, input int exp_nbytes);
        logic [7:0]   exp_b [$];
        logic [W-1:0] exp_a [$];
        int t0, waited, budget, bad;
        for (int i = 0; i < cnt; i++) begin
            int a;
            logic [B-1:0] w;
            a = (base + i) % Depth;
            exp_a.push_back(W'(a));
            w = mem[a];
            for (int j = 0; j < NB; j++) exp_b.push_back(8'(w >> (8 * (NB - 1 - j))));
        end
        clear_obs();
        rmode  = mode;
        budget = 40 + cnt * (1 + NB) * 6;
        @(posedge clk);
        #1;
        start_i     = 1'b1;
        base_addr_i = W'(base);
        count_i     = (W + 1)'(cnt);
        t0          = cyc;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        waited  = 1;
        while (done_cnt == 0 && waited < budget) begin
            @(posedge clk);
            waited++;
            #1;
            start_i = (restart > 0 && waited == restart);
            if (start_i) begin
                base_addr_i = W'(base + 16);
                count_i     = (W + 1)'(2);
            end
        end
        start_i = 1'b0;
        @(negedge clk);
        chk("busy_after_done", longint'(busy_o), 0);
        repeat ((restart > 0) ? 15 : 3) @(posedge clk);
        chk("done_pulses", done_cnt, 1);
        if (exp_lat >= 0) chk("done_latency", done_cyc - t0, exp_lat);
        chk("busy_cycles", busy_cnt, done_cyc - t0);
        chk("rd_cycles", rd_cnt, cnt);
        chk("byte_count", obs_bytes.size(), exp_nbytes);
        chk("stall_stable", stall_viol, 0);
        if (mode == 0) chk("valid_cycles", valid_cnt, cnt * NB);
        bad = -1;
        for (int i = 0; i < exp_b.size() && i < obs_bytes.size(); i++)
            if (bad < 0 && obs_bytes[i] != exp_b[i]) bad = i;
        if (bad >= 0) chk($sformatf("byte[%0d]", bad), longint'(obs_bytes[bad]),
                          longint'(exp_b[bad]));
        bad = -1;
        for (int i = 0; i < exp_a.size() && i < obs_addrs.size(); i++)
            if (bad < 0 && obs_addrs[i] != exp_a[i]) bad = i;
        if (bad >= 0) chk($sformatf("addr[%0d]", bad), longint'(obs_addrs[bad]),
                          longint'(exp_a[bad]));
    endtask

    typedef struct {
        int base;
        int cnt;
        int mode;
        int exp_lat;
        int restart;
        int exp_nbytes;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int w;
        start_i     = 1'b0;
        base_addr_i = '0;
        count_i     = '0;
        for (int i = 0; i < Depth; i++) mem[i] = B'($urandom);
        mem[0] = 16'h1234;
        mem[1] = 16'hABCD;
        mem[2] = 16'h0001;
        mem[3] = 16'hFFFF;

        vecs[0] = '{base: 0,     cnt: 3, mode: 0, exp_lat: 10, restart: 0, exp_nbytes: 6};
        vecs[1] = '{base: 0,     cnt: 3, mode: 1, exp_lat: -1, restart: 0, exp_nbytes: 6};
        vecs[2] = '{base: 'h7FE, cnt: 4, mode: 0, exp_lat: 13, restart: 0, exp_nbytes: 8};
        vecs[3] = '{base: 5,     cnt: 0, mode: 0, exp_lat: 1,  restart: 0, exp_nbytes: 0};
        vecs[4] = '{base: 3,     cnt: 1, mode: 2, exp_lat: -1, restart: 0, exp_nbytes: 2};
        vecs[5] = '{base: 0,     cnt: 3, mode: 0, exp_lat: 10, restart: 3, exp_nbytes: 6};

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_idle_outputs("reset");
        rst_n = 1'b1;

        foreach (vecs[i])
            run_xfer(vecs[i].base, vecs[i].cnt, vecs[i].mode, vecs[i].exp_lat,
                     vecs[i].restart, vecs[i].exp_nbytes);

        for (int k = 0; k < 12; k++) begin
            int base, cnt, mode;
            base = int'($urandom_range(0, Depth - 1));
            cnt  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 10));
            mode = int'($urandom_range(0, 2));
            run_xfer(base, cnt, mode, (mode == 0) ? ((cnt == 0) ? 1 : cnt * (1 + NB) + 1) : -1,
                     0, cnt * NB);
        end

        run_xfer(int'($urandom_range(0, Depth - 1)), Depth, 0, Depth * (1 + NB) + 1, 0,
                 Depth * NB);

        // Abort with reset in the middle of the second word.
        clear_obs();
        rmode = 0;
        @(posedge clk);
        #1;
        start_i     = 1'b1;
        base_addr_i = '0;
        count_i     = (W + 1)'(3);
        @(posedge clk);
        #1;
        start_i = 1'b0;
        w = 0;
        while (obs_bytes.size() < 3 && w < 50) begin
            @(posedge clk);
            w++;
        end
        chk("bytes_before_reset", obs_bytes.size(), 3);
        chk("valid_before_reset", longint'(dif.tx_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_idle_outputs("abort");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        chk("done_after_abort", done_cnt, 0);
        chk("bytes_after_abort", obs_bytes.size(), 3);
        run_xfer(2, 2, 0, 7, 0, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
